// File: rtl/mem_access_stage_pkg.sv
// Shared pipeline types for the MEM stage: EXE/MEM and MEM/WB bundles,
// memToReg encodings and the pixel-port FSM states.
package stages_definition_pkg;
    localparam int DMEM_ADDR_W = 10;
    localparam int IMG_WIDTH   = 256;
    localparam int IMG_HEIGHT  = 256;
    localparam int PIX_ADDR_W  = 16;
    localparam int COORD_W     = 16;

    localparam logic [1:0] MTR_ALU  = 2'b00;
    localparam logic [1:0] MTR_DMEM = 2'b01;
    localparam logic [1:0] MTR_PIX  = 2'b10;
    localparam logic [1:0] MTR_TRIG = 2'b11;

    typedef enum logic [1:0] {PIX_IDLE, PIX_REQ, PIX_RESP, PIX_DONE} pix_state_t;

    typedef struct packed {
        logic       regWrite;
        logic       pcSrc;
        logic [1:0] memToReg;
        logic       memWrite;
        logic       memPixWrite;
    } exe_mem_cu_signals;

    typedef struct packed {
        logic [31:0]        aluResult;
        logic [31:0]        trigResult;
        logic [COORD_W-1:0] Ax;
        logic [COORD_W-1:0] Ay;
        logic [3:0]         Rd;
        logic [31:0]        WD;
    } exe_mem_interface;

    typedef struct packed {
        logic       regWrite;
        logic       pcSrc;
        logic [1:0] memToReg;
    } mem_wb_cu_signals;

    typedef struct packed {
        logic [31:0] dataMemRead;
        logic [31:0] pixMemRead;
        logic [31:0] aluResult;
        logic [31:0] trigResult;
    } mem_wb_interface;

    // Coordinates are two's complement; negative values are out of range.
    function automatic logic coord_in_range(input logic [COORD_W-1:0] ax, input logic [COORD_W-1:0] ay,
                                            input int w, input int h);
        int sx, sy;
        sx = int'($signed(ax));
        sy = int'($signed(ay));
        return (sx >= 0) && (sx < w) && (sy >= 0) && (sy < h);
    endfunction
endpackage

// File: rtl/mem_access_stage_if.sv
// Memory-side bus of the MEM stage: async data memory plus the handshaked pixel memory.
interface mem_access_stage_if #(
    parameter int DMEM_ADDR_W = 10,
    parameter int PIX_ADDR_W  = 16
);
    logic [DMEM_ADDR_W-1:0] dmem_addr;
    logic [31:0]            dmem_wdata;
    logic                   dmem_we;
    logic [31:0]            dmem_rdata;
    logic                   pix_req;
    logic                   pix_we;
    logic [PIX_ADDR_W-1:0]  pix_addr;
    logic [7:0]             pix_wdata;
    logic                   pix_ready;
    logic                   pix_rvalid;
    logic [7:0]             pix_rdata;

    modport master (
        output dmem_addr, dmem_wdata, dmem_we, pix_req, pix_we, pix_addr, pix_wdata,
        input  dmem_rdata, pix_ready, pix_rvalid, pix_rdata
    );
    modport slave (
        input  dmem_addr, dmem_wdata, dmem_we, pix_req, pix_we, pix_addr, pix_wdata,
        output dmem_rdata, pix_ready, pix_rvalid, pix_rdata
    );
endinterface

// File: rtl/mem_access_stage_pix_mem_port.sv
// Pixel-memory port: request/response FSM, linear address and read-data hold.
module pix_mem_port
    import stages_definition_pkg::*;
#(
    parameter int IMG_W  = IMG_WIDTH,
    parameter int IMG_H  = IMG_HEIGHT,
    parameter int ADDR_W = PIX_ADDR_W
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               op_wr_i,
    input  logic               op_rd_i,
    input  logic [COORD_W-1:0] ax_i,
    input  logic [COORD_W-1:0] ay_i,
    input  logic [7:0]         wdata_i,
    output logic               req_o,
    output logic               we_o,
    output logic [ADDR_W-1:0]  addr_o,
    output logic [7:0]         wdata_o,
    input  logic               ready_i,
    input  logic               rvalid_i,
    input  logic [7:0]         rdata_i,
    output logic               busy_o,
    output logic               done_o,
    output logic [31:0]        rdata_o,
    output logic               oob_o
);
    pix_state_t state_q;
    logic [7:0] hold_q;
    logic       oob_q;
    logic       op_any, in_rng, go;

    assign op_any  = op_wr_i | op_rd_i;
    assign in_rng  = coord_in_range(ax_i, ay_i, IMG_W, IMG_H);
    assign go      = op_any & in_rng;
    assign we_o    = op_wr_i;
    assign wdata_o = wdata_i;
    assign addr_o  = ADDR_W'(int'($signed(ay_i)) * IMG_W + int'($signed(ax_i)));
    assign oob_o   = oob_q;
    assign done_o  = (state_q == PIX_DONE);
    assign req_o   = ((state_q == PIX_IDLE) & go) | (state_q == PIX_REQ);
    // Stall is forced low under reset so upstream never freezes while flushing.
    assign busy_o  = ~rst & (req_o | (state_q == PIX_RESP));
    assign rdata_o = (done_o & op_rd_i) ? {24'b0, hold_q} : 32'b0;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= PIX_IDLE;
            hold_q  <= '0;
            oob_q   <= 1'b0;
        end else begin
            case (state_q)
                PIX_IDLE: begin
                    if (go)
                        state_q <= ready_i ? (op_wr_i ? PIX_DONE : PIX_RESP) : PIX_REQ;
                    if (op_any & ~in_rng)
                        oob_q <= 1'b1;
                end
                PIX_REQ:  if (ready_i) state_q <= op_wr_i ? PIX_DONE : PIX_RESP;
                PIX_RESP: if (rvalid_i) begin
                    hold_q  <= rdata_i;
                    state_q <= PIX_DONE;
                end
                PIX_DONE: state_q <= PIX_IDLE;
                default:  state_q <= PIX_IDLE;
            endcase
        end
    end
endmodule

// File: rtl/mem_access_stage.sv
// MEM pipeline stage: data-memory access, pixel-port stall control and the MEM/WB register.
module mem_access_stage
    import stages_definition_pkg::*;
#(
    parameter int DMEM_AW = DMEM_ADDR_W,
    parameter int IMG_W   = IMG_WIDTH,
    parameter int IMG_H   = IMG_HEIGHT,
    parameter int PIX_AW  = PIX_ADDR_W
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    input  exe_mem_cu_signals  in_cu,
    input  exe_mem_interface   in_data,
    output logic               stall_o,
    mem_access_stage_if.master mem,
    output logic               out_valid,
    output mem_wb_cu_signals   out_cu,
    output mem_wb_interface    out_data,
    output logic [3:0]         out_rd,
    output logic               pix_oob
);
    logic             pix_wr, pix_rd, pix_done;
    logic [31:0]      pix_rdata;
    logic             valid_q, valid_d;
    mem_wb_cu_signals cu_q, cu_d;
    mem_wb_interface  data_q, data_d;
    logic [3:0]       rd_q, rd_d;

    // A simultaneous pixel write and pixel read is handled as a write.
    assign pix_wr = in_valid & in_cu.memPixWrite;
    assign pix_rd = in_valid & (in_cu.memToReg == MTR_PIX) & ~in_cu.memPixWrite;

    pix_mem_port #(.IMG_W(IMG_W), .IMG_H(IMG_H), .ADDR_W(PIX_AW)) u_pix (
        .clk      (clk),
        .rst      (rst),
        .op_wr_i  (pix_wr),
        .op_rd_i  (pix_rd),
        .ax_i     (in_data.Ax),
        .ay_i     (in_data.Ay),
        .wdata_i  (in_data.WD[7:0]),
        .req_o    (mem.pix_req),
        .we_o     (mem.pix_we),
        .addr_o   (mem.pix_addr),
        .wdata_o  (mem.pix_wdata),
        .ready_i  (mem.pix_ready),
        .rvalid_i (mem.pix_rvalid),
        .rdata_i  (mem.pix_rdata),
        .busy_o   (stall_o),
        .done_o   (pix_done),
        .rdata_o  (pix_rdata),
        .oob_o    (pix_oob)
    );

    assign mem.dmem_addr  = in_data.aluResult[DMEM_AW+1:2];
    assign mem.dmem_wdata = in_data.WD;
    // Stores fire only in the non-stalled cycle, so a store paired with a pixel op writes once.
    assign mem.dmem_we    = in_valid & in_cu.memWrite & ~stall_o;

    always_comb begin
        valid_d = in_valid & ~stall_o;
        cu_d    = '0;
        data_d  = data_q;
        rd_d    = rd_q;
        if (!stall_o) begin
            if (in_valid) cu_d = '{regWrite: in_cu.regWrite, pcSrc: in_cu.pcSrc, memToReg: in_cu.memToReg};
            data_d = '{dataMemRead: mem.dmem_rdata, pixMemRead: pix_rdata,
                       aluResult: in_data.aluResult, trigResult: in_data.trigResult};
            rd_d   = in_data.Rd;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= 1'b0;
            cu_q    <= '0;
            data_q  <= '0;
            rd_q    <= '0;
        end else begin
            valid_q <= valid_d;
            cu_q    <= cu_d;
            data_q  <= data_d;
            rd_q    <= rd_d;
        end
    end

    assign out_valid = valid_q;
    assign out_cu    = cu_q;
    assign out_data  = data_q;
    assign out_rd    = rd_q;

    logic unused_done;
    assign unused_done = pix_done;
endmodule
